mem_access_unit: RTL and testbench

- MEM-stage access controller between the EX/MEM pipeline register and the word-only, negedge-clocked 1024x32 data memory.
- Converts byte, halfword and word loads/stores into word accesses. Sub-word stores use read-modify-write (RMW).
- Loads are extracted and sign/zero-extended. Results are registered toward the MEM/WB register.
- Raises a one-cycle stall for sub-word stores only.

---
 rtl/mem_access_unit_pkg.sv | 33 +++
 rtl/mem_access_unit_lane_align.sv | 46 ++++
 rtl/mem_access_unit.sv | 171 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: access-size encodings, FSM
// states, data width and a lane-offset helper.
package mem_access_unit_pkg;

  localparam int unsigned DATA_W = 32;

  // req_size encoding; 2'b11 is decoded as a word access.
  typedef enum logic [1:0] {
    SzByte = 2'b00,
    SzHalf = 2'b01,
    SzWord = 2'b10
  } size_e;

  typedef enum logic {
    StIdle,
    StRmwWr
  } state_e;

  // Byte offset of the addressed lane with the low bits forced aligned for the
  // access size: halfwords use addr[1] only, words always start at lane 0.
  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [1:0] off;
    if (size == SzByte) begin
      off = addr_lo;
    end else if (size == SzHalf) begin
      off = {addr_lo[1], 1'b0};
    end else begin
      off = 2'b00;
    end
    return off;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Lane alignment for the MEM stage (combinational).
//   extract: pulls the byte/half/word selected by off_i out of rdata_i and
//            zero- or sign-extends it (ext_o).
//   merge:   overlays the low bytes of wdata_i onto rdata_i at lane off_i, keeping
//            the untouched lanes from rdata_i (merge_o).
// Ports: size_i (access size), off_i (aligned byte offset), signed_i,
//        rdata_i (memory word), wdata_i (right-justified store data),
//        ext_o, merge_o.
module mem_access_unit_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic [1:0]        off_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] ext_o,
  output logic [DATA_W-1:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    ext_o   = rdata_i;
    merge_o = rdata_i;
    case (size_i)
      SzByte: begin
        ext_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
        merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SzHalf: begin
        ext_o = {{16{signed_i & half_sel[15]}}, half_sel};
        merge_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: begin
        ext_o   = rdata_i;
        merge_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access controller between EX/MEM and a word-only, negedge-clocked
// data memory. Loads complete in one cycle; word stores write directly; byte and
// half stores do a read-modify-write over two cycles with a one-cycle stall.
// Optional build macro: MISALIGN_TRAP_EN -- misaligned half/word requests are
// suppressed and flagged on misalign_o instead of being forced aligned.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_*_i                       memory request from EX/MEM
//   stall_o                       hold IF..EX/MEM this cycle
//   ld_valid_o, ld_data_o         registered load result toward MEM/WB
//   misalign_o                    registered one-cycle alignment fault
//   mem_read_o, mem_write_o, mem_addr_o, mem_din_o, mem_dout_i   data memory side
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = mem_access_unit_pkg::DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  input  logic              req_load_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  input  logic [31:0]       req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              stall_o,
  output logic              ld_valid_o,
  output logic [DATA_W-1:0] ld_data_o,
  output logic              misalign_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o,
  input  logic [DATA_W-1:0] mem_dout_i
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ld_valid_q, ld_valid_d;
  logic [DATA_W-1:0] ld_data_q, ld_data_d;
  logic              misalign_q, misalign_d;

  logic              misal;
  logic              sub_word;
  logic [1:0]        al_size;
  logic [1:0]        al_off;
  logic [DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] merge_data;
  logic              read_raw, write_raw, stall_raw;

  // Upper address bits alias onto the memory.
  logic unused_addr;
  assign unused_addr = ^req_addr_i[31:ADDR_W+2];

  assign sub_word = ~req_size_i[1];

  always_comb begin
    misal = 1'b0;
`ifdef MISALIGN_TRAP_EN
    if (state_q == StIdle && req_valid_i) begin
      misal = (req_size_i == SzHalf && req_addr_i[0]) ||
              (req_size_i[1] && req_addr_i[1:0] != 2'b00);
    end
`endif
  end

  // The aligner serves the live request in IDLE and the latched store in RMW_WR.
  always_comb begin
    if (state_q == StRmwWr) begin
      al_size = size_q;
      al_off  = off_q;
    end else begin
      al_size = req_size_i;
      al_off  = align_off(req_size_i, req_addr_i[1:0]);
    end
  end

  mem_access_unit_lane_align u_lane_align (
    .size_i   (al_size),
    .off_i    (al_off),
    .signed_i (req_signed_i),
    .rdata_i  (mem_dout_i),
    .wdata_i  (wdata_q),
    .ext_o    (ext_data),
    .merge_o  (merge_data)
  );

  always_comb begin
    read_raw   = 1'b0;
    write_raw  = 1'b0;
    stall_raw  = 1'b0;
    mem_addr_o = req_addr_i[ADDR_W+1:2];
    mem_din_o  = req_wdata_i;

    state_d    = state_q;
    addr_d     = addr_q;
    off_d      = off_q;
    size_d     = size_q;
    wdata_d    = wdata_q;
    ld_valid_d = 1'b0;
    ld_data_d  = ld_data_q;
    misalign_d = misal;

    case (state_q)
      StIdle: begin
        if (req_valid_i && !misal) begin
          if (req_load_i) begin
            read_raw   = 1'b1;
            ld_valid_d = 1'b1;
            ld_data_d  = ext_data;
          end else if (!sub_word) begin
            write_raw = 1'b1;
          end else begin
            // Fetch the old word now, write the merged word next cycle.
            read_raw  = 1'b1;
            stall_raw = 1'b1;
            addr_d    = req_addr_i[ADDR_W+1:2];
            off_d     = al_off;
            size_d    = req_size_i;
            wdata_d   = req_wdata_i;
            state_d   = StRmwWr;
          end
        end
      end
      StRmwWr: begin
        write_raw  = 1'b1;
        mem_addr_o = addr_q;
        mem_din_o  = merge_data;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Gating by rst_ni keeps the strobes quiet while reset is held, even with a
  // request present upstream.
  assign mem_read_o  = read_raw & rst_ni;
  assign mem_write_o = write_raw & rst_ni;
  assign stall_o     = stall_raw & rst_ni;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      off_q      <= '0;
      size_q     <= '0;
      wdata_q    <= '0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      off_q      <= off_d;
      size_q     <= size_d;
      wdata_q    <= wdata_d;
      ld_valid_q <= ld_valid_d;
      ld_data_q  <= ld_data_d;
      misalign_q <= misalign_d;
    end
  end

  assign ld_valid_o = ld_valid_q;
  assign ld_data_o  = ld_data_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a negedge-clocked 1024x32 memory model.
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_load_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_signed_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        stall_o, ld_valid_o, misalign_o, mem_read_o, mem_write_o;
  logic [31:0] ld_data_o, mem_din_o;
  logic [31:0] mem_dout_i = '0;
  logic [9:0]  mem_addr_o;

  logic [31:0] mem [1024];

  int n_cmp = 0;
  int n_err = 0;
  int stalls;

  always #5 clk_i = ~clk_i;

  mem_access_unit #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_load_i   (req_load_i),
    .req_size_i   (req_size_i),
    .req_signed_i (req_signed_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .stall_o      (stall_o),
    .ld_valid_o   (ld_valid_o),
    .ld_data_o    (ld_data_o),
    .misalign_o   (misalign_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_din_o    (mem_din_o),
    .mem_dout_i   (mem_dout_i)
  );

  always @(negedge clk_i) begin
    if (mem_write_o) mem[mem_addr_o] <= mem_din_o;
    if (mem_read_o) mem_dout_i <= mem[mem_addr_o];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called 1 time unit after a posedge; returns 1 time unit after the posedge
  // that completes the operation. Counts stall cycles, bounded.
  task automatic op(input logic load, input logic [1:0] size, input logic sgn,
                    input logic [31:0] addr, input logic [31:0] wdata, output int n_stall);
    bit done;
    int n;
    req_valid_i  = 1'b1;
    req_load_i   = load;
    req_size_i   = size;
    req_signed_i = sgn;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    n_stall = 0;
    done = 1'b0;
    n = 0;
    while (!done && n < 4) begin
      #2;
      if (stall_o) n_stall++;
      else done = 1'b1;
      @(posedge clk_i);
      #1;
      n++;
    end
    req_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    // Request present during reset: strobes must stay low.
    req_valid_i = 1'b1;
    req_load_i  = 1'b0;
    req_size_i  = 2'b00;
    req_addr_i  = 32'h40;
    #3;
    check_eq("rst_mem_read", {31'b0, mem_read_o}, 32'd0);
    check_eq("rst_mem_write", {31'b0, mem_write_o}, 32'd0);
    check_eq("rst_stall", {31'b0, stall_o}, 32'd0);
    check_eq("rst_ld_valid", {31'b0, ld_valid_o}, 32'd0);
    check_eq("rst_ld_data", ld_data_o, 32'h0);
    check_eq("rst_misalign", {31'b0, misalign_o}, 32'd0);
    req_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    op(1'b0, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, stalls);
    check_eq("sw_stall", stalls, 0);
    check_eq("sw_mem", mem[10'h10], 32'hDEADBEEF);

    op(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, stalls);
    check_eq("lw_stall", stalls, 0);
    check_eq("lw_valid", {31'b0, ld_valid_o}, 32'd1);
    check_eq("lw_data", ld_data_o, 32'hDEADBEEF);

    op(1'b1, 2'b00, 1'b1, 32'h43, 32'h0, stalls);
    check_eq("lb_data", ld_data_o, 32'hFFFFFFDE);
    op(1'b1, 2'b00, 1'b0, 32'h43, 32'h0, stalls);
    check_eq("lbu_data", ld_data_o, 32'h000000DE);

    op(1'b0, 2'b00, 1'b0, 32'h41, 32'h11, stalls);
    check_eq("sb_stall", stalls, 1);
    check_eq("sb_ld_valid", {31'b0, ld_valid_o}, 32'd0);
    check_eq("sb_mem", mem[10'h10], 32'hDEAD11EF);
    op(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, stalls);
    check_eq("lw_after_sb", ld_data_o, 32'hDEAD11EF);

    op(1'b0, 2'b01, 1'b0, 32'h42, 32'hA5A5, stalls);
    check_eq("sh_stall", stalls, 1);
    check_eq("sh_mem", mem[10'h10], 32'hA5A511EF);
    op(1'b1, 2'b01, 1'b1, 32'h42, 32'h0, stalls);
    check_eq("lh_data", ld_data_o, 32'hFFFFA5A5);
    op(1'b1, 2'b01, 1'b0, 32'h40, 32'h0, stalls);
    check_eq("lhu_data", ld_data_o, 32'h000011EF);

    // Size 2'b11 is a word; address bit 12 aliases back onto word 0x10.
    op(1'b1, 2'b11, 1'b0, 32'h1040, 32'h0, stalls);
    check_eq("alias_lw", ld_data_o, 32'hA5A511EF);

`ifdef MISALIGN_TRAP_EN
    req_valid_i = 1'b1;
    req_load_i  = 1'b1;
    req_size_i  = 2'b10;
    req_addr_i  = 32'h41;
    #2;
    check_eq("mis_mem_read", {31'b0, mem_read_o}, 32'd0);
    check_eq("mis_mem_write", {31'b0, mem_write_o}, 32'd0);
    check_eq("mis_stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    check_eq("mis_flag", {31'b0, misalign_o}, 32'd1);
    check_eq("mis_ld_valid", {31'b0, ld_valid_o}, 32'd0);
    @(posedge clk_i);
    #1;
    check_eq("mis_flag_clear", {31'b0, misalign_o}, 32'd0);
`else
    op(1'b1, 2'b10, 1'b0, 32'h41, 32'h0, stalls);
    check_eq("unal_lw_data", ld_data_o, 32'hA5A511EF);
    check_eq("unal_lw_valid", {31'b0, ld_valid_o}, 32'd1);
    check_eq("unal_misalign", {31'b0, misalign_o}, 32'd0);
`endif

    // Reset asserted during the RMW write cycle.
    req_valid_i  = 1'b1;
    req_load_i   = 1'b0;
    req_size_i   = 2'b00;
    req_signed_i = 1'b0;
    req_addr_i   = 32'h40;
    req_wdata_i  = 32'h77;
    #2;
    check_eq("rmw_rst_stall", {31'b0, stall_o}, 32'd1);
    @(posedge clk_i);
    #1;
    check_eq("rmw_wr_active", {31'b0, mem_write_o}, 32'd1);
    #1;
    rst_ni = 1'b0;
    #1;
    check_eq("rmw_rst_write", {31'b0, mem_write_o}, 32'd0);
    check_eq("rmw_rst_ld_valid", {31'b0, ld_valid_o}, 32'd0);
    req_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    check_eq("rmw_rst_mem", mem[10'h10], 32'hA5A511EF);
    op(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, stalls);
    check_eq("post_rst_stall", stalls, 0);
    check_eq("post_rst_lw", ld_data_o, 32'hA5A511EF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
